forward_select_ctrl: RTL and testbench

//  Producer of the 2-bit Selector codes that drive the EX-stage operand 4:1 muxes (ALU A/B) in the pipelined core.

---
 rtl/forward_select_ctrl.sv | 117 +++++++++++
 tb/tb_forward_select_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/forward_select_ctrl.sv
// Operand-forwarding selector generator and load-use stall controller for the EX-stage ALU muxes.
// Define FWD_STALL_CNT_EN to build the saturating load-use stall counter on stall_cnt.
module forward_select_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_link,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_wait,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  pc_hold,
    output logic                  idex_bubble,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_EXM  = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;

    typedef enum logic {RUN, LDSTALL} state_e;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  ld;
        logic [REG_ADDR_W-1:0] dest;
    } stage_t;

    // Only EX and MEM producers feed the muxes: whatever sits in MEM during ID
    // is in WB during EX, which is exactly the write-back (01) source.
    stage_t ex_q, mem_q;
    state_e state_q;

    function automatic logic match(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.wr & (s.dest != '0) & (s.dest == r);
    endfunction

    logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic       load_use, stall, id_enter;
    logic [1:0] sel_a_d, sel_b_d;
    stage_t     ex_d;

    always_comb begin
        ex_hit_rs  = id_use_rs & match(ex_q, id_rs);
        ex_hit_rt  = id_use_rt & match(ex_q, id_rt);
        mem_hit_rs = id_use_rs & match(mem_q, id_rs);
        mem_hit_rt = id_use_rt & match(mem_q, id_rt);

        // In LDSTALL the load has moved on and EX holds the bubble, so gating
        // on RUN only makes explicit that one load stalls a consumer once.
        load_use = id_valid & ex_q.valid & ex_q.ld & (ex_hit_rs | ex_hit_rt)
                   & (state_q == RUN);
        stall    = load_use & ~flush;
        id_enter = id_valid & ~flush & ~load_use;

        pc_hold     = stall | mem_wait;
        idex_bubble = stall & ~mem_wait;

        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        ex_d    = '0;
        if (id_enter) begin
            ex_d = '{valid: 1'b1, wr: id_reg_write, ld: id_mem_read, dest: id_dest};
            if (id_link)         sel_a_d = SEL_LINK;
            else if (ex_hit_rs)  sel_a_d = SEL_EXM;
            else if (mem_hit_rs) sel_a_d = SEL_WB;
            if (ex_hit_rt)       sel_b_d = SEL_EXM;
            else if (mem_hit_rt) sel_b_d = SEL_WB;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_sel_a <= SEL_RF;
            fwd_sel_b <= SEL_RF;
            state_q   <= RUN;
        end else if (!mem_wait) begin
            ex_q      <= ex_d;
            mem_q     <= ex_q;
            fwd_sel_a <= sel_a_d;
            fwd_sel_b <= sel_b_d;
            case (state_q)
                RUN:     if (stall) state_q <= LDSTALL;
                LDSTALL: state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (idex_bubble && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_forward_select_ctrl.sv
// Directed-vector bench for forward_select_ctrl: forwarding codes, load-use stall, flush, freeze, link, reset.
module tb_forward_select_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_link, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       flush, mem_wait;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       pc_hold, idex_bubble;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    forward_select_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_link(id_link), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_wait(mem_wait), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .pc_hold(pc_hold), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage instruction: valid, rs, rt, use_rs, use_rt, dest, reg_write, mem_read, link.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic wr, input logic ld, input logic lnk);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dest = dst; id_reg_write = wr; id_mem_read = ld; id_link = lnk;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_check(input string tag);
`ifdef FWD_STALL_CNT_EN
        check(tag, 32'(stall_cnt), 32'(exp_cnt));
`else
        check(tag, 32'(stall_cnt), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; mem_wait = 1'b0;
        nop();
        #12;
        check("rst_sel_a", 32'(fwd_sel_a), 32'd0);
        check("rst_sel_b", 32'(fwd_sel_b), 32'd0);
        check("rst_pc_hold", 32'(pc_hold), 32'd0);
        check("rst_bubble", 32'(idex_bubble), 32'd0);
        cnt_check("rst_cnt");
        reset = 1'b1;
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        check("add_sel_a", 32'(fwd_sel_a), 32'd0);
        drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); tick();
        check("exfwd_sel_a", 32'(fwd_sel_a), 32'd2);
        check("exfwd_sel_b", 32'(fwd_sel_b), 32'd0);

        // add $3 ; nop ; or $6,$7,$3
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        nop(); tick();
        drive(1, 5'd7, 5'd3, 1, 1, 5'd6, 1, 0, 0); tick();
        check("memfwd_sel_a", 32'(fwd_sel_a), 32'd0);
        check("memfwd_sel_b", 32'(fwd_sel_b), 32'd1);

        // add $0,$1,$2 ; sub $4,$0,$0 -> register 0 never forwarded
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); tick();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0); tick();
        check("r0_sel_a", 32'(fwd_sel_a), 32'd0);
        check("r0_sel_b", 32'(fwd_sel_b), 32'd0);

        // Two producers of $3 back-to-back: newest (EX) wins
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0); tick();
        check("prio_sel_a", 32'(fwd_sel_a), 32'd2);
        check("prio_sel_b", 32'(fwd_sel_b), 32'd2);

        // lw $8,0($9) ; add $10,$8,$8
        nop(); tick(); tick();
        drive(1, 5'd9, 5'd8, 1, 0, 5'd8, 1, 1, 0); tick();
        drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0); #1;
        check("lu_pc_hold", 32'(pc_hold), 32'd1);
        check("lu_bubble", 32'(idex_bubble), 32'd1);
        tick(); exp_cnt = 1;
        check("lu_bub_sel_a", 32'(fwd_sel_a), 32'd0);
        check("lu_stall_pc_hold", 32'(pc_hold), 32'd0);
        cnt_check("lu_cnt");
        tick();
        check("lu_sel_a", 32'(fwd_sel_a), 32'd1);
        check("lu_sel_b", 32'(fwd_sel_b), 32'd1);

        // lw $8 ; consumer flushed in the same cycle
        nop(); tick(); tick();
        drive(1, 5'd9, 5'd8, 1, 0, 5'd8, 1, 1, 0); tick();
        drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0); flush = 1'b1; #1;
        check("fl_pc_hold", 32'(pc_hold), 32'd0);
        check("fl_bubble", 32'(idex_bubble), 32'd0);
        tick(); flush = 1'b0;
        check("fl_sel_b", 32'(fwd_sel_b), 32'd0);
        cnt_check("fl_cnt");
        #1;
        check("fl_run_pc_hold", 32'(pc_hold), 32'd0);
        tick();
        check("fl_run_sel_a", 32'(fwd_sel_a), 32'd1);

        // add $9 ; lw $8,0($9) ; add $10,$8,$8 under 3 cycles of mem_wait
        nop(); tick(); tick();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd9, 5'd8, 1, 0, 5'd8, 1, 1, 0); tick();
        check("mw_lw_sel_a", 32'(fwd_sel_a), 32'd2);
        drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0); mem_wait = 1'b1; #1;
        check("mw_pc_hold", 32'(pc_hold), 32'd1);
        check("mw_bubble", 32'(idex_bubble), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mw_frozen_sel_a", 32'(fwd_sel_a), 32'd2);
        end
        cnt_check("mw_cnt");
        mem_wait = 1'b0; #1;
        check("mw_rel_pc_hold", 32'(pc_hold), 32'd1);
        check("mw_rel_bubble", 32'(idex_bubble), 32'd1);
        tick(); exp_cnt = 2;
        check("mw_bub_sel_a", 32'(fwd_sel_a), 32'd0);
        cnt_check("mw_rel_cnt");
        tick();
        check("mw_sel_a", 32'(fwd_sel_a), 32'd1);
        check("mw_sel_b", 32'(fwd_sel_b), 32'd1);

        // jal: A operand is the link value
        drive(1, 5'd0, 5'd0, 0, 0, 5'd31, 1, 0, 1); tick();
        check("jal_sel_a", 32'(fwd_sel_a), 32'd3);
        check("jal_sel_b", 32'(fwd_sel_b), 32'd0);

        // Reset during LDSTALL aborts the stall
        nop(); tick(); tick();
        drive(1, 5'd9, 5'd8, 1, 0, 5'd8, 1, 1, 0); tick();
        drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0); tick(); exp_cnt = 3;
        cnt_check("rs_pre_cnt");
        #2; reset = 1'b0; #1;
        exp_cnt = 0;
        check("rs_sel_a", 32'(fwd_sel_a), 32'd0);
        check("rs_pc_hold", 32'(pc_hold), 32'd0);
        check("rs_bubble", 32'(idex_bubble), 32'd0);
        cnt_check("rs_cnt");
        reset = 1'b1;
        tick();
        check("rs_after_sel_a", 32'(fwd_sel_a), 32'd0);
        check("rs_after_sel_b", 32'(fwd_sel_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
